// File: rtl/hs_phy_pkg.sv
// hs_phy_pkg: shared encodings and constants for the HS transmit path.
// The FSM state encoding is fixed so the receive side and debug tools agree on it.
package hs_phy_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HS_SYNC_BYTE = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_DATA  = 2'd2,
        ST_TRAIL = 2'd3
    } hs_state_e;

    // True in the states where the shifter is clocking bits onto the line
    function automatic logic hs_is_serial(input hs_state_e s);
        return (s == ST_SYNC) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/hs_tx_serializer_if.sv
// hs_tx_serializer_if: byte-side handshake plus line-side outputs of the HS serializer.
// master = byte source / line observer, slave = the serializer itself.
interface hs_tx_serializer_if;
    import hs_phy_pkg::*;

    logic [BYTE_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY;
    logic              HS_TX_DATA;
    logic              HS_TX_EN;
    logic              FLAG_SERIALIZE;
    logic              TX_DONE;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  HS_TX_DATA,
        input  HS_TX_EN,
        input  FLAG_SERIALIZE,
        input  TX_DONE
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output HS_TX_DATA,
        output HS_TX_EN,
        output FLAG_SERIALIZE,
        output TX_DONE
    );

endinterface

// File: rtl/hs_tx_shifter.sv
// hs_tx_shifter: byte shift register and bit counter for the HS serializer.
// Load wins over shift; the counter wraps 7 -> 0 so consecutive bytes need no gap.
module hs_tx_shifter
    import hs_phy_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_bit,
    output logic              o_last
);

    logic [BYTE_W-1:0] r_shreg;
    logic [2:0]        r_cnt;

    // Load a fresh byte, or shift the current one right by one bit per clock
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_shreg <= '0;
            r_cnt   <= 3'd0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= 3'd0;
        end else if (i_shift) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + 3'd1;
        end
    end

    assign o_bit  = r_shreg[0];
    assign o_last = (r_cnt == 3'd7);

endmodule

// File: rtl/hs_tx_serializer.sv
// hs_tx_serializer: HS transmit serializer. Sends a sync byte, then each accepted
// byte LSB-first, one bit per TxDDRClkHS rising edge.
// Optional feature macro: HS_TX_TRAILER_EN adds a TRAIL_CYCLES-long trailer that
// drives the inverse of the last data bit before returning to IDLE.
module hs_tx_serializer
    import hs_phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE = HS_SYNC_BYTE
`ifdef HS_TX_TRAILER_EN
    ,
    parameter int unsigned TRAIL_CYCLES = 4
`endif
)
(
    input  logic                TxDDRClkHS,
    input  logic                RST,
    input  logic                Enable,
    hs_tx_serializer_if.slave   bus
);

    hs_state_e         r_state;
    logic              r_done;

    logic              w_active;
    logic              w_load;
    logic              w_shift;
    logic              w_clear;
    logic              w_bit;
    logic              w_last;
    logic [BYTE_W-1:0] w_loadData;

`ifdef HS_TX_TRAILER_EN
    localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYCLES - 1);

    logic [7:0]        r_trailCnt;
    logic              r_lastBit;
`endif

    assign w_active   = hs_is_serial(r_state);
    assign w_clear    = !Enable;
    assign w_load     = Enable && bus.TX_VALID &&
                        ((r_state == ST_IDLE) || (w_active && w_last));
    assign w_loadData = (r_state == ST_IDLE) ? SYNC_BYTE : bus.TX_DATA;
    assign w_shift    = Enable && w_active;

    hs_tx_shifter u_shifter (
        .i_clk   (TxDDRClkHS),
        .i_rst_n (RST),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_loadData),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    // Burst sequencing: IDLE -> SYNC -> DATA* -> (TRAIL) -> IDLE, aborted by Enable low
    always_ff @(posedge TxDDRClkHS) begin
        if (!RST || !Enable) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
`ifdef HS_TX_TRAILER_EN
            r_trailCnt <= 8'd0;
            r_lastBit  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.TX_VALID) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC, ST_DATA: begin
`ifdef HS_TX_TRAILER_EN
                    r_lastBit <= w_bit;
`endif
                    if (w_last) begin
                        if (bus.TX_VALID) begin
                            r_state <= ST_DATA;
                        end else begin
`ifdef HS_TX_TRAILER_EN
                            r_state    <= ST_TRAIL;
                            r_trailCnt <= 8'd0;
`else
                            r_state    <= ST_IDLE;
                            r_done     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef HS_TX_TRAILER_EN
                ST_TRAIL: begin
                    if (r_trailCnt == TRAIL_LAST) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_trailCnt <= 8'd0;
                    end else begin
                        r_trailCnt <= r_trailCnt + 8'd1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line bit: shifter LSB while serialising, inverted last bit in the trailer, else 0
    always_comb begin
        bus.HS_TX_DATA = 1'b0;
        if (w_active) begin
            bus.HS_TX_DATA = w_bit;
        end
`ifdef HS_TX_TRAILER_EN
        else if (r_state == ST_TRAIL) begin
            bus.HS_TX_DATA = ~r_lastBit;
        end
`endif
    end

    assign bus.HS_TX_EN       = (r_state != ST_IDLE);
    assign bus.TX_READY       = Enable && w_active && w_last;
    assign bus.FLAG_SERIALIZE = (r_state == ST_DATA) && w_last;
    assign bus.TX_DONE        = r_done;

endmodule

// File: tb/tb_hs_tx_serializer.sv
// tb_hs_tx_serializer: self-checking bench for hs_tx_serializer.
// Build with +define+HS_TX_TRAILER_EN to exercise the trailer variant.
module tb_hs_tx_serializer;

    localparam logic [7:0] SYNC  = 8'hB8;
    localparam int         TRAIL = 4;

    typedef struct {
        logic [7:0]  txData;
        logic [15:0] expLine;
        logic        expTrail;
    } vec_t;

    logic TxDDRClkHS;
    logic RST;
    logic Enable;

    hs_tx_serializer_if bus();

    hs_tx_serializer dut (
        .TxDDRClkHS (TxDDRClkHS),
        .RST        (RST),
        .Enable     (Enable),
        .bus        (bus)
    );

    int         compareCount  = 0;
    int         mismatchCount = 0;
    int         hsSeen        = 0;
    int         rxCount       = 0;
    int         rxBytes       = 0;
    bit         rxOn          = 1'b0;
    logic [7:0] rxShift       = 8'h00;

    logic       expLine[$];
    logic [7:0] expBytes[$];
    logic [7:0] txBytes[$];

    vec_t       vecs[5];

    // Free-running bit clock
    initial TxDDRClkHS = 1'b0;
    always #5 TxDDRClkHS = ~TxDDRClkHS;

    // Safety net so a stuck run still ends with a visible failure
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Loopback receiver model: drop the sync byte, rebuild bytes LSB-first
    task automatic rxModel();
        if (bus.HS_TX_EN === 1'b1) begin
            rxCount++;
            if (rxCount > 8) begin
                rxShift = {bus.HS_TX_DATA, rxShift[7:1]};
                if ((rxCount % 8) == 0) begin
                    rxBytes++;
                    if (expBytes.size() == 0) begin
                        checkOutput("loopback_extra", 32'd1, 32'd0);
                    end else begin
                        checkOutput("loopback_byte", rxShift, expBytes.pop_front());
                    end
                end
            end
        end else begin
            rxCount = 0;
        end
    endtask

    task automatic step();
        @(posedge TxDDRClkHS);
        #1;
        if (rxOn) rxModel();
    endtask

    task automatic pushByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) expLine.push_back(b[i]);
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        bus.TX_DATA  = data;
        bus.TX_VALID = 1'b1;
        step();
    endtask

    // Checks the end of a normal burst: optional trailer, then IDLE with a single TX_DONE
    task automatic finishBurst(input logic trailLevel);
`ifdef HS_TX_TRAILER_EN
        bus.TX_VALID = 1'b1;
        for (int t = 0; t < TRAIL; t++) begin
            checkOutput("trail_en", bus.HS_TX_EN, 1'b1);
            checkOutput("trail_line", bus.HS_TX_DATA, trailLevel);
            checkOutput("trail_ready", bus.TX_READY, 1'b0);
            checkOutput("trail_done", bus.TX_DONE, 1'b0);
            if (t == TRAIL - 1) bus.TX_VALID = 1'b0;
            step();
        end
`else
        if (trailLevel === 1'bx) $display("[TB] trailer level unknown");
`endif
        checkOutput("end_en", bus.HS_TX_EN, 1'b0);
        checkOutput("end_line", bus.HS_TX_DATA, 1'b0);
        checkOutput("end_done", bus.TX_DONE, 1'b1);
        checkOutput("end_ready", bus.TX_READY, 1'b0);
        step();
        checkOutput("done_pulse_width", bus.TX_DONE, 1'b0);
        checkOutput("idle_en", bus.HS_TX_EN, 1'b0);
    endtask

    // Streams txBytes with VALID held; abortAt >= 0 drops Enable at that line bit index
    task automatic runStream(input int abortAt);
        logic lastBit;
        logic consume;
        int   bound;
        bound   = 8 * (txBytes.size() + 1);
        hsSeen  = 0;
        lastBit = 1'b0;
        expLine.delete();
        bus.TX_DATA  = txBytes[0];
        bus.TX_VALID = 1'b1;
        step();
        pushByte(SYNC);
        for (int idx = 0; idx < bound; idx++) begin
            checkOutput("burst_en", bus.HS_TX_EN, 1'b1);
            if (expLine.size() == 0) begin
                checkOutput("burst_underflow", 32'd1, 32'd0);
            end else begin
                lastBit = expLine.pop_front();
                checkOutput("burst_line", bus.HS_TX_DATA, lastBit);
            end
            checkOutput("burst_flag", bus.FLAG_SERIALIZE, ((idx % 8) == 7) && (idx >= 8));
            checkOutput("burst_done", bus.TX_DONE, 1'b0);
            if (idx == abortAt) begin
                Enable = 1'b0;
                #1;
                checkOutput("abort_ready", bus.TX_READY, 1'b0);
                step();
                checkOutput("abort_en", bus.HS_TX_EN, 1'b0);
                checkOutput("abort_line", bus.HS_TX_DATA, 1'b0);
                checkOutput("abort_flag", bus.FLAG_SERIALIZE, 1'b0);
                checkOutput("abort_done", bus.TX_DONE, 1'b0);
                bus.TX_VALID = 1'b0;
                step();
                checkOutput("abort_no_trailer", bus.HS_TX_EN, 1'b0);
                checkOutput("abort_no_done", bus.TX_DONE, 1'b0);
                Enable = 1'b1;
                txBytes.delete();
                expLine.delete();
                return;
            end
            checkOutput("burst_ready", bus.TX_READY, (idx % 8) == 7);
            if (bus.TX_READY === 1'b1 && bus.TX_VALID === 1'b1) hsSeen++;
            consume = ((idx % 8) == 7) && (txBytes.size() > 0);
            step();
            if (consume) begin
                pushByte(txBytes[0]);
                expBytes.push_back(txBytes.pop_front());
                if (txBytes.size() > 0) bus.TX_DATA = txBytes[0];
                else bus.TX_VALID = 1'b0;
            end else if ((idx % 8) == 7) begin
                finishBurst(~lastBit);
                return;
            end
        end
        checkOutput("burst_bound", 32'd1, 32'd0);
    endtask

    initial begin
        logic [7:0] syncVar;
        syncVar = SYNC;

        // Bit i of expLine is the i-th bit on the line: sync LSB-first, then data LSB-first
        vecs[0] = '{8'hA5, 16'b1010_0101_1011_1000, 1'b0};
        vecs[1] = '{8'h00, 16'b0000_0000_1011_1000, 1'b1};
        vecs[2] = '{8'hFF, 16'b1111_1111_1011_1000, 1'b0};
        vecs[3] = '{8'h80, 16'b1000_0000_1011_1000, 1'b0};
        vecs[4] = '{8'h01, 16'b0000_0001_1011_1000, 1'b1};

        RST          = 1'b0;
        Enable       = 1'b1;
        bus.TX_DATA  = 8'h00;
        bus.TX_VALID = 1'b0;
        step();
        step();
        checkOutput("reset_en", bus.HS_TX_EN, 1'b0);
        checkOutput("reset_line", bus.HS_TX_DATA, 1'b0);
        checkOutput("reset_ready", bus.TX_READY, 1'b0);
        checkOutput("reset_flag", bus.FLAG_SERIALIZE, 1'b0);
        checkOutput("reset_done", bus.TX_DONE, 1'b0);
        RST = 1'b1;
        step();

        $display("[TB] single-byte vectors");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].txData);
            for (int i = 0; i < 16; i++) begin
                checkOutput("vec_en", bus.HS_TX_EN, 1'b1);
                checkOutput("vec_line", bus.HS_TX_DATA, vecs[v].expLine[i]);
                checkOutput("vec_flag", bus.FLAG_SERIALIZE, i == 15);
                checkOutput("vec_ready", bus.TX_READY, (i % 8) == 7);
                checkOutput("vec_done", bus.TX_DONE, 1'b0);
                step();
                if (i == 7) bus.TX_VALID = 1'b0;
            end
            finishBurst(vecs[v].expTrail);
        end

        $display("[TB] sync-only burst");
        applyStimulus(8'h5A);
        bus.TX_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("synconly_en", bus.HS_TX_EN, 1'b1);
            checkOutput("synconly_line", bus.HS_TX_DATA, syncVar[i]);
            checkOutput("synconly_flag", bus.FLAG_SERIALIZE, 1'b0);
            checkOutput("synconly_ready", bus.TX_READY, i == 7);
            step();
        end
        finishBurst(1'b0);

        $display("[TB] back-to-back stream");
        txBytes.push_back(8'h00);
        txBytes.push_back(8'hFF);
        txBytes.push_back(8'h3C);
        runStream(-1);
        checkOutput("stream_handshakes", hsSeen, 32'd3);

        $display("[TB] abort during second byte, then restart");
        txBytes.push_back(8'h11);
        txBytes.push_back(8'h22);
        txBytes.push_back(8'h33);
        runStream(19);
        txBytes.push_back(8'h44);
        runStream(-1);

        $display("[TB] abort on a handshake cycle");
        txBytes.push_back(8'h66);
        txBytes.push_back(8'h77);
        runStream(15);

        $display("[TB] reset mid-burst");
        applyStimulus(8'hC3);
        for (int i = 0; i < 12; i++) step();
        RST          = 1'b0;
        bus.TX_VALID = 1'b0;
        step();
        checkOutput("midreset_en", bus.HS_TX_EN, 1'b0);
        checkOutput("midreset_line", bus.HS_TX_DATA, 1'b0);
        checkOutput("midreset_ready", bus.TX_READY, 1'b0);
        checkOutput("midreset_done", bus.TX_DONE, 1'b0);
        RST = 1'b1;
        step();
        checkOutput("midreset_idle", bus.HS_TX_EN, 1'b0);

        $display("[TB] loopback of 64 random bytes");
        expBytes.delete();
        rxBytes = 0;
        rxCount = 0;
        rxOn    = 1'b1;
        for (int i = 0; i < 64; i++) txBytes.push_back(8'($urandom_range(0, 255)));
        runStream(-1);
        rxOn = 1'b0;
        checkOutput("loopback_count", rxBytes, 32'd64);
        checkOutput("loopback_left", expBytes.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
